// File: rtl/xor_sched_pkg.sv
// Shared definitions for the round-robin XOR scheduler: FSM encoding and counter width.
package xor_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam int OPS_CNT_W = 16;

endpackage

// File: rtl/xor_word.sv
// Shared combinational XOR datapath; the single resource the scheduler arbitrates.
module xor_word #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor_rr_scheduler.sv
// Round-robin scheduler serialising NREQ requesters onto one xor_word, one op in flight.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | searching from rr_ptr for a valid requester; grant + latch operands
//   EXEC  | latched operands pass through xor_word into resp_y/resp_id
//   RESP  | resp_valid high, result held until resp_ready
module xor_rr_scheduler
    import xor_sched_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDTH-1:0]      resp_y,
    output logic [IDW-1:0]        resp_id,
    output logic                  busy,
    output logic [OPS_CNT_W-1:0]  ops_done
);

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   op_id;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] xor_y;

    logic [NREQ-1:0]  grant_oh;
    logic [IDW-1:0]   grant_id;
    logic             grant_vld;
    logic [IDW-1:0]   ptr_nxt;

    // Cyclic priority search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        int idx;
        grant_oh  = '0;
        grant_id  = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_vld && req_valid[idx]) begin
                grant_vld     = 1'b1;
                grant_id      = IDW'(idx);
                grant_oh[idx] = 1'b1;
            end
        end
    end

    assign ptr_nxt = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready  = (state == IDLE && !rst) ? grant_oh : '0;
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    xor_word #(.WIDTH(WIDTH)) u_xor_word (
        .a (op_a),
        .b (op_b),
        .y (xor_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            op_id    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            resp_y   <= '0;
            resp_id  <= '0;
            ops_done <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        op_a   <= req_a[int'(grant_id)*WIDTH +: WIDTH];
                        op_b   <= req_b[int'(grant_id)*WIDTH +: WIDTH];
                        op_id  <= grant_id;
                        rr_ptr <= ptr_nxt;
                    end
                end
                EXEC: begin
                    resp_y  <= xor_y;
                    resp_id <= op_id;
                end
                RESP: begin
                    if (resp_ready) begin
                        ops_done <= ops_done + OPS_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_rr_scheduler.sv
// Directed testbench for xor_rr_scheduler with hand-computed expected values.
module tb_xor_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [WIDTH-1:0]      resp_y;
    logic [IDW-1:0]        resp_id;
    logic                  busy;
    logic [15:0]           ops_done;

    int n_checks = 0;
    int n_errors = 0;

    xor_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
        .resp_id    (resp_id),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    // Expects IDLE on entry with resp_ready=1; runs one full 3-cycle operation.
    task automatic run_op(input int g, input logic [7:0] exp_y);
        logic [NREQ-1:0] exp_rdy;
        exp_rdy = '0;
        exp_rdy[g] = 1'b1;
        #1;
        check("grant", 32'(req_ready), 32'(exp_rdy));
        tick();
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_no_resp", 32'(resp_valid), 32'd0);
        tick();
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_id", 32'(resp_id), 32'(g));
        check("resp_y", 32'(resp_y), 32'(exp_y));
        tick();
        check("resp_done", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;

        // 1: asynchronous reset mid-clock, then idle with no requests
        #23;
        rst = 1'b1;
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_ops_done", 32'(ops_done), 32'd0);
        check("rst_resp_y", 32'(resp_y), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_req_ready", 32'(req_ready), 32'd0);

        // 2: single request from requester 2, operands changed after grant
        set_ops(2, 8'hA5, 8'h0F);
        req_valid = 4'b0100;
        #1;
        check("t2_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        set_ops(2, 8'h00, 8'h00);
        check("t2_exec_busy", 32'(busy), 32'd1);
        check("t2_exec_rdy", 32'(req_ready), 32'd0);
        check("t2_exec_no_resp", 32'(resp_valid), 32'd0);
        tick();
        check("t2_resp_valid", 32'(resp_valid), 32'd1);
        check("t2_resp_y", 32'(resp_y), 32'hAA);
        check("t2_resp_id", 32'(resp_id), 32'd2);
        resp_ready = 1'b1;
        tick();
        check("t2_ops_done", 32'(ops_done), 32'd1);
        check("t2_idle", 32'(busy), 32'd0);

        // 3: all requesting from rr_ptr=0 -> order 0,1,2,3,0
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        set_ops(0, 8'h11, 8'hF0);
        set_ops(1, 8'h22, 8'hF0);
        set_ops(2, 8'h33, 8'hF0);
        set_ops(3, 8'h44, 8'hF0);
        req_valid = 4'b1111;
        run_op(0, 8'hE1);
        run_op(1, 8'hD2);
        run_op(2, 8'hC3);
        run_op(3, 8'hB4);
        run_op(0, 8'hE1);
        check("t3_ops_done", 32'(ops_done), 32'd5);

        // 4: back-pressure in RESP for 5 cycles
        resp_ready = 1'b0;
        #1;
        check("t4_grant", 32'(req_ready), 32'h2);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", 32'(resp_valid), 32'd1);
            check("t4_hold_y", 32'(resp_y), 32'hD2);
            check("t4_hold_id", 32'(resp_id), 32'd1);
            check("t4_hold_rdy", 32'(req_ready), 32'd0);
            tick();
        end
        check("t4_still_valid", 32'(resp_valid), 32'd1);
        resp_ready = 1'b1;
        tick();
        req_valid = '0;
        check("t4_ops_done", 32'(ops_done), 32'd6);
        check("t4_idle", 32'(busy), 32'd0);

        // 5: reset during EXEC discards the op
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        check("t5_in_exec", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_valid", 32'(resp_valid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_resp", 32'(resp_valid), 32'd0);
        end
        check("t5_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        check("t5_ops_done", 32'(ops_done), 32'd0);
        set_ops(0, 8'h5A, 8'h3C);
        set_ops(3, 8'hC3, 8'h81);
        req_valid = 4'b1001;
        run_op(0, 8'h66);
        run_op(3, 8'h42);
        req_valid = '0;

        // 6: operand extremes and ops_done wrap
        set_ops(1, 8'hFF, 8'hFF);
        req_valid = 4'b0010;
        run_op(1, 8'h00);
        set_ops(1, 8'h00, 8'hFF);
        run_op(1, 8'hFF);
        req_valid = '0;
        check("t6_ops_done", 32'(ops_done), 32'd4);
        force dut.ops_done = 16'hFFFF;
        #1;
        release dut.ops_done;
        #1;
        check("t6_forced", 32'(ops_done), 32'hFFFF);
        tick();
        req_valid = 4'b0010;
        run_op(1, 8'hFF);
        req_valid = '0;
        check("t6_wrap", 32'(ops_done), 32'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
